// File: rtl/md_unit.sv
// ============================================================================
//  md_unit
//  Multi-cycle multiply/divide unit owning the HI/LO registers.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0]    C_MULT_LAT = CW'(MULT_LAT);
    localparam logic [CW-1:0]    C_DIV_LAT  = CW'(DIV_LAT);
    localparam logic [CW-1:0]    C_CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [CW-1:0]        cnt_q,  cnt_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     hi_q,   hi_d;
    logic [WIDTH-1:0]     lo_q,   lo_d;
    logic [2*WIDTH-1:0]   pend_q, pend_d;

    logic                 accept;
    logic [2*WIDTH-1:0]   a_ext, b_ext, prod;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag, b_div;
    logic [WIDTH-1:0]     uq, ur, quo, rem;

    // Multiply: sign-extend to 2*WIDTH so a plain product gives the exact signed result.
    always_comb begin
        a_ext = (op == OP_MULT) ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
        b_ext = (op == OP_MULT) ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
        prod  = a_ext * b_ext;
    end

    // Divide on magnitudes, then restore signs; MIN/-1 falls out as LO=A, HI=0.
    always_comb begin
        a_neg = (op == OP_DIV) && A[WIDTH-1];
        b_neg = (op == OP_DIV) && B[WIDTH-1];
        a_mag = a_neg ? (~A + C_ONE) : A;
        b_mag = b_neg ? (~B + C_ONE) : B;
        b_div = (b_mag == '0) ? C_ONE : b_mag;
        uq    = a_mag / b_div;
        ur    = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? (~uq + C_ONE) : uq;
        rem   = a_neg ? (~ur + C_ONE) : ur;
        if (B == '0) begin
            quo = '1;
            rem = A;
        end
    end

    assign accept = start && !busy_q && (op <= OP_MTLO);

    always_comb begin
        cnt_d  = cnt_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        pend_d = pend_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - C_CNT_ONE;
            if (cnt_q == C_CNT_ONE) begin
                hi_d = pend_q[2*WIDTH-1:WIDTH];
                lo_d = pend_q[WIDTH-1:0];
            end
        end else if (accept) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    pend_d = prod;
                    cnt_d  = C_MULT_LAT;
                end
                OP_DIV, OP_DIVU: begin
                    pend_d = {rem, quo};
                    cnt_d  = C_DIV_LAT;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            pend_q <= pend_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
//  tb_md_unit
//  Scoreboard bench for md_unit at default and narrow (8-bit) parameters.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        start32 = 1'b0;
    logic [2:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32;
    logic [31:0] hi32, lo32;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8;
    logic [7:0]  hi8, lo8;

    int total = 0;
    int bad   = 0;

    logic [63:0] q32[$];
    logic [15:0] q8[$];

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) u_dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32),
        .A(a32), .B(b32), .busy(busy32), .HI(hi32), .LO(lo32)
    );

    md_unit #(.WIDTH(8), .MULT_LAT(1), .DIV_LAT(3)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .A(a8), .B(b8), .busy(busy8), .HI(hi8), .LO(lo8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: 64-bit integer arithmetic, returns {HI, LO}.
    function automatic logic [63:0] model32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] t, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t  = '0;
        case (o)
            3'd0: t = 64'(sa * sb);
            3'd1: t = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) t = {a, 32'hFFFF_FFFF};
                else begin
                    qv = 64'(sa / sb);
                    rv = 64'(sa % sb);
                    t  = {rv[31:0], qv[31:0]};
                end
            end
            3'd3: t = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: t = '0;
        endcase
        return t;
    endfunction

    // Issues one request on the 32-bit unit, scrambles inputs after accept, waits for busy to drop.
    task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int cyc);
        op32 = o; a32 = a; b32 = b; start32 = 1'b1;
        tick();
        start32 = 1'b0;
        a32 = $urandom; b32 = $urandom; op32 = 3'($urandom_range(0, 3));
        cyc = 0;
        while (busy32 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, output int cyc);
        op8 = o; a8 = a; b8 = b; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        cyc = 0;
        while (busy8 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        int busy_seen;
        total++;
        if (busy32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b HI=%h LO=%h required busy=0 HI=0 LO=0", busy32, hi32, lo32);
        end
        busy_seen = 0;
        start32 = 1'b1; op32 = 3'd4; a32 = 32'h1234_5678;
        tick();
        busy_seen |= int'(busy32);
        op32 = 3'd5; a32 = 32'h9ABC_DEF0;
        tick();
        busy_seen |= int'(busy32);
        start32 = 1'b0;
        total++;
        if (hi32 !== 32'h1234_5678 || lo32 !== 32'h9ABC_DEF0 || busy_seen != 0) begin
            bad++;
            $display("FAIL mthi_mtlo: HI=%h LO=%h busy_seen=%0d required HI=12345678 LO=9abcdef0 busy_seen=0",
                     hi32, lo32, busy_seen);
        end
        start32 = 1'b1; op32 = 3'd0; a32 = 32'd3; b32 = 32'd4;
        tick();
        start32 = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        total++;
        if (busy32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
            bad++;
            $display("FAIL reset_midrun: busy=%b HI=%h LO=%h required busy=0 HI=0 LO=0", busy32, hi32, lo32);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (8) tick();
        total++;
        if (busy32 !== 1'b0 || hi32 !== 32'd0 || lo32 !== 32'd0) begin
            bad++;
            $display("FAIL reset_no_commit: busy=%b HI=%h LO=%h required busy=0 HI=0 LO=0", busy32, hi32, lo32);
        end
    endtask

    // Directed test-plan vectors with fixed expectations, plus model-checked random ops.
    task automatic test_arith();
        logic [2:0]  ops[6]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2};
        logic [31:0] as[6]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000};
        logic [31:0] bs[6]   = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [63:0] exps[6] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0001_FFFF_FFFE,
                                 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003,
                                 64'h0000_0005_FFFF_FFFF, 64'h0000_0000_8000_0000};
        int cyc, lat;
        logic [63:0] e;
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 6; i++) begin
            q32.push_back(exps[i]);
            run32(ops[i], as[i], bs[i], cyc);
            lat = (ops[i] < 3'd2) ? 5 : 10;
            e = q32.pop_front();
            total++;
            if ({hi32, lo32} !== e || cyc != lat) begin
                bad++;
                $display("FAIL arith_vec%0d: HI:LO=%h busy_cycles=%0d required HI:LO=%h busy_cycles=%0d",
                         i, {hi32, lo32}, cyc, e, lat);
            end
        end
        for (int i = 0; i < 8; i++) begin
            o = 3'(i % 4);
            a = $urandom;
            b = (i == 6) ? 32'd0 : ((i == 7) ? 32'hFFFF_FFFF : $urandom);
            if (i == 5) b = b >> 20;
            q32.push_back(model32(o, a, b));
            run32(o, a, b, cyc);
            e = q32.pop_front();
            total++;
            if ({hi32, lo32} !== e) begin
                bad++;
                $display("FAIL arith_rand%0d: op=%0d A=%h B=%h HI:LO=%h required %h", i, o, a, b, {hi32, lo32}, e);
            end
        end
    endtask

    task automatic test_ignored();
        logic [63:0] e, old;
        int cyc, hold_bad;
        old = {hi32, lo32};
        q32.push_back(model32(3'd3, 32'd1000, 32'd7));
        start32 = 1'b1; op32 = 3'd3; a32 = 32'd1000; b32 = 32'd7;
        tick();
        start32 = 1'b0;
        cyc = 1; hold_bad = 0;
        while (busy32 && cyc < 200) begin
            if ({hi32, lo32} !== old) hold_bad++;
            start32 = (cyc == 2 || cyc == 5);
            op32    = (cyc == 2) ? 3'd5 : 3'd0;
            a32     = (cyc == 2) ? 32'h0000_DEAD : $urandom;
            b32     = $urandom;
            tick();
            start32 = 1'b0;
            if (busy32) cyc++;
        end
        e = q32.pop_front();
        total++;
        if ({hi32, lo32} !== e || lo32 === 32'h0000_DEAD || cyc != 10) begin
            bad++;
            $display("FAIL ignored_req: HI:LO=%h busy_cycles=%0d required HI:LO=%h busy_cycles=10",
                     {hi32, lo32}, cyc, e);
        end
        total++;
        if (hold_bad != 0) begin
            bad++;
            $display("FAIL hilo_hold: changed_cycles=%0d required 0", hold_bad);
        end
        tick();
        total++;
        if (busy32 !== 1'b0 || {hi32, lo32} !== e) begin
            bad++;
            $display("FAIL after_commit: busy=%b HI:LO=%h required busy=0 HI:LO=%h", busy32, {hi32, lo32}, e);
        end
    endtask

    task automatic test_narrow();
        logic [15:0] e;
        int cyc;
        q8.push_back(16'h4000);
        run8(3'd0, 8'h80, 8'h80, cyc);
        e = q8.pop_front();
        total++;
        if ({hi8, lo8} !== e || cyc != 1) begin
            bad++;
            $display("FAIL narrow_mult: HI:LO=%h busy_cycles=%0d required HI:LO=%h busy_cycles=1", {hi8, lo8}, cyc, e);
        end
        q8.push_back({8'd4, 8'd28});
        run8(3'd3, 8'd200, 8'd7, cyc);
        e = q8.pop_front();
        total++;
        if ({hi8, lo8} !== e || cyc != 3) begin
            bad++;
            $display("FAIL narrow_divu: HI:LO=%h busy_cycles=%0d required HI:LO=%h busy_cycles=3", {hi8, lo8}, cyc, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        // start held high: edge E accepts, E+1 (commit) ignores, E+2 accepts the second request.
        q8.push_back(16'd15 * 16'd17);
        q8.push_back(16'd250 * 16'd3);
        start8 = 1'b1; op8 = 3'd1; a8 = 8'd15; b8 = 8'd17;
        tick();
        a8 = 8'd250; b8 = 8'd3;
        tick();
        e = q8.pop_front();
        total++;
        if (busy8 !== 1'b0 || {hi8, lo8} !== e) begin
            bad++;
            $display("FAIL b2b_first: busy=%b HI:LO=%h required busy=0 HI:LO=%h", busy8, {hi8, lo8}, e);
        end
        tick();
        start8 = 1'b0;
        total++;
        if (busy8 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept: busy=%b required 1", busy8);
        end
        tick();
        e = q8.pop_front();
        total++;
        if (busy8 !== 1'b0 || {hi8, lo8} !== e) begin
            bad++;
            $display("FAIL b2b_second: busy=%b HI:LO=%h required busy=0 HI:LO=%h", busy8, {hi8, lo8}, e);
        end
        start8 = 1'b1; op8 = 3'd6; a8 = 8'hAA;
        tick();
        start8 = 1'b0;
        total++;
        if (busy8 !== 1'b0 || {hi8, lo8} !== e) begin
            bad++;
            $display("FAIL noop_op6: busy=%b HI:LO=%h required busy=0 HI:LO=%h", busy8, {hi8, lo8}, e);
        end
    endtask

    initial begin
        #12 reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_arith();
        test_ignored();
        test_narrow();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
